imem_fetch_ctrl: RTL and testbench

Fetch sequencer for the 256-word instruction ROM (imem). It owns the program counter, drives the ROM word address and registers each fetched instruction into a one-entry output stage. The stage uses a valid/ready handshake toward decode. It handles branch redirects, backpressure and end-of-program halt, and sits between imem and the decode/control path of the single-cycle/pipelined core.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/imem_fetch_ctrl.sv | 103 ++++++++++
 tb/tb_imem_fetch_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam int              WORD_BYTES       = 4;
  localparam logic [63:0]     DEFAULT_RESET_PC = 64'h0;
  localparam int              IMEM_ADDR_W      = 8;
  localparam int              IMEM_DEPTH       = 2 ** IMEM_ADDR_W;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses imem and presents one registered
// instruction to decode over valid/ready. Optional macro FETCH_HALT_ON_ZERO_EN.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              N        = 32,
  parameter int              ADDR_W   = IMEM_ADDR_W,
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [N-1:0]      imem_q,
  output logic [N-1:0]      instr,
  output logic [PC_W-1:0]   instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              halt
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [N-1:0]      instr_q, instr_d;
  logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;

  logic              stage_free;
  logic              pc_in_range;
  logic              end_marker;
  logic [1:0]        unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  assign imem_addr   = fetch_pc_q[ADDR_W+1:2];
  assign stage_free  = !valid_q || instr_ready;
  assign pc_in_range = ~|fetch_pc_q[PC_W-1:ADDR_W+2];

`ifdef FETCH_HALT_ON_ZERO_EN
  assign end_marker = (imem_q == '0);
`else
  assign end_marker = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    if (redirect) begin
      // A taken branch squashes the held instruction even if decode is accepting it.
      valid_d    = 1'b0;
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
      state_d    = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (stage_free) begin
            if (pc_in_range && !end_marker) begin
              instr_d    = imem_q;
              instr_pc_d = fetch_pc_q;
              valid_d    = 1'b1;
              fetch_pc_d = fetch_pc_q + PC_W'(WORD_BYTES);
            end else begin
              valid_d = 1'b0;
              state_d = HALT;
            end
          end
        end
        HALT: begin
          if (instr_ready) valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halt        = (state_q == HALT) && !valid_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios with literal expectations, then
// randomized ready/redirect traffic against a behavioural fetch model.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_q;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        halt;

  logic [31:0] rom [256];
  int          compared   = 0;
  int          mismatched = 0;

  // Behavioural model: what decode should see, derived from the fetch rules.
  logic [63:0] m_pc;
  logic        m_halted;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_ipc;
  logic [31:0] m_word;

  always #5 clk = ~clk;

  assign imem_q = rom[imem_addr];

  imem_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 64'h0; m_halted = 1'b0; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
    end else if (redirect) begin
      m_valid  = 1'b0;
      m_pc     = redirect_pc & ~64'h3;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (!m_valid || instr_ready) begin
        m_word = rom[m_pc[9:2]];
`ifdef FETCH_HALT_ON_ZERO_EN
        if (m_pc < 64'h400 && m_word != 32'h0) begin
`else
        if (m_pc < 64'h400) begin
`endif
          m_instr = m_word; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
        end else begin
          m_valid = 1'b0; m_halted = 1'b1;
        end
      end
    end else if (instr_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_valid", {63'h0, instr_valid}, {63'h0, m_valid});
    chk("model_halt",  {63'h0, halt}, {63'h0, m_halted && !m_valid});
    chk("model_addr",  {56'h0, imem_addr}, {56'h0, m_pc[9:2]});
    if (m_valid) begin
      chk("model_instr", {32'h0, instr}, {32'h0, m_instr});
      chk("model_pc",    instr_pc, m_ipc);
    end
  end

  initial begin
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rom[0] = 32'hd29fffe1; rom[1] = 32'hf8000001; rom[2] = 32'hb400001f;
    rom[255] = 32'hcafe0001;

    repeat (3) @(negedge clk);
    chk("rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_halt",  {63'h0, halt}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);
    chk("rst_addr",  {56'h0, imem_addr}, 64'h0);
    reset = 1'b0;

    @(negedge clk);
    chk("seq0_instr", {32'h0, instr}, 64'hd29fffe1);
    chk("seq0_pc", instr_pc, 64'h0);
    chk("seq0_valid", {63'h0, instr_valid}, 64'h1);
    @(negedge clk);
    chk("seq1_instr", {32'h0, instr}, 64'hf8000001);
    chk("seq1_pc", instr_pc, 64'h4);
    instr_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_instr", {32'h0, instr}, 64'hf8000001);
      chk("stall_pc", instr_pc, 64'h4);
      chk("stall_addr", {56'h0, imem_addr}, 64'h2);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("seq2_instr", {32'h0, instr}, 64'hb400001f);
    chk("seq2_pc", instr_pc, 64'h8);

    redirect = 1'b1; redirect_pc = 64'h6;
    @(negedge clk);
    chk("redir_drop", {63'h0, instr_valid}, 64'h0);
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_instr", {32'h0, instr}, 64'hf8000001);
    chk("redir_pc", instr_pc, 64'h4);
    @(negedge clk);
    chk("redir_next_pc", instr_pc, 64'h8);

    redirect = 1'b1; redirect_pc = 64'h3fc;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    chk("last_valid", {63'h0, instr_valid}, 64'h1);
    chk("last_pc", instr_pc, 64'h3fc);
    chk("last_instr", {32'h0, instr}, 64'hcafe0001);
    @(negedge clk);
    chk("end_halt", {63'h0, halt}, 64'h1);
    chk("end_valid", {63'h0, instr_valid}, 64'h0);
    @(negedge clk);
    chk("end_halt_hold", {63'h0, halt}, 64'h1);
    redirect = 1'b1; redirect_pc = 64'h0;
    @(negedge clk);
    chk("restart_halt", {63'h0, halt}, 64'h0);
    redirect = 1'b0;
    @(negedge clk);
    chk("restart_instr", {32'h0, instr}, 64'hd29fffe1);
    chk("restart_pc", instr_pc, 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("run_pc8", instr_pc, 64'h8);
    @(negedge clk);
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("zero_halt", {63'h0, halt}, 64'h1);
    chk("zero_valid", {63'h0, instr_valid}, 64'h0);
`else
    chk("zero_valid", {63'h0, instr_valid}, 64'h1);
    chk("zero_instr", {32'h0, instr}, 64'h0);
    chk("zero_pc", instr_pc, 64'hc);
`endif

    redirect = 1'b1; redirect_pc = 64'h0;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    instr_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {63'h0, instr_valid}, 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("async_rst_instr", {32'h0, instr}, 64'h0);
    chk("async_rst_pc", instr_pc, 64'h0);
    chk("async_rst_halt", {63'h0, halt}, 64'h0);
    @(negedge clk);
    reset = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_instr", {32'h0, instr}, 64'hd29fffe1);
    chk("post_rst_pc", instr_pc, 64'h0);

    for (int i = 3; i < 256; i++)
      rom[i] = ($urandom_range(0, 19) == 0) ? 32'h0 : $urandom;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) < 8)
        redirect_pc = 64'($urandom_range(0, 32'h43f));
      else
        redirect_pc = {$urandom, $urandom};
    end
    redirect = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
